// File: rtl/alu_acc_pipe.sv
// Registered W-bit ALU with accumulator, carry chaining and a one-deep output stage.
// Define ALU_ACC_PIPE_SAT_EN to clamp carrying adds to all-ones and borrowing subtracts to zero.
module alu_acc_pipe #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   ACC_RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic         use_acc,
  input  logic         acc_wr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         c,
  output logic         z,
  output logic         n,
  output logic         v,
  output logic [W-1:0] acc
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_ADC   = 3'b101;
  localparam logic [2:0] OP_SBB   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Handshake: a transfer happens on any edge where valid && ready are both high.
  // in_ready is high whenever the output slot is empty or is being drained this cycle,
  // so an op can be accepted in the same cycle the previous result leaves.
  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  logic         cf;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin;
  logic [W:0]   add_s;
  logic [W:0]   sub_d;
  logic [W-1:0] res_raw;
  logic [W-1:0] res_q;
  logic         res_c;
  logic         res_v;
  logic         is_add;
  logic         is_sub;

  assign opa = use_acc ? acc : a;
  assign opb = b;
  assign cin = ((op == OP_ADC) || (op == OP_SBB)) && cf;

  // Both sums are kept at W+1 bits so bit W is the carry or the borrow.
  assign add_s = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, cin};
  assign sub_d = {1'b0, opa} - {1'b0, opb} - {{W{1'b0}}, cin};

  always_comb begin
    res_raw = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        is_add  = 1'b1;
        res_raw = add_s[W-1:0];
        res_c   = add_s[W];
        res_v   = (opa[W-1] == opb[W-1]) && (add_s[W-1] != opa[W-1]);
      end
      OP_SUB, OP_SBB: begin
        is_sub  = 1'b1;
        res_raw = sub_d[W-1:0];
        res_c   = sub_d[W];
        res_v   = (opa[W-1] != opb[W-1]) && (sub_d[W-1] != opa[W-1]);
      end
      OP_AND:   res_raw = opa & opb;
      OP_OR:    res_raw = opa | opb;
      OP_XOR:   res_raw = opa ^ opb;
      OP_PASSB: res_raw = opb;
      default:  res_raw = '0;
    endcase
  end

`ifdef ALU_ACC_PIPE_SAT_EN
  // Carry and overflow still describe the unclamped result; only q is clamped.
  always_comb begin
    res_q = res_raw;
    if (is_add && res_c) res_q = '1;
    if (is_sub && res_c) res_q = '0;
  end
`else
  logic unused_kind;
  assign unused_kind = is_add ^ is_sub;
  assign res_q = res_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      c         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      cf        <= 1'b0;
      acc       <= ACC_RST;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= res_q;
      c         <= res_c;
      z         <= (res_q == '0);
      n         <= res_q[W-1];
      v         <= res_v;
      cf        <= res_c;
      if (acc_wr) acc <= res_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_acc_pipe.md
Name: alu_acc_pipe

Overview:
Parametrised W-bit registered ALU with a valid/ready handshake, an eight-operation set, a flag register and an internal accumulator. It generalises the 4-bit add/subtract unit:
- operand width set by parameter
- carry/borrow chaining across transactions (ADC/SBB)
- optional accumulator as operand A
- one-cycle pipelined result with back-pressure

It sits between the instruction sequencer and the register-file writeback.

Parameters:
W, 8, operand/result width in bits (legal 2..32).
ACC_RST, 0, reset value of the accumulator (W bits).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept an operation this cycle.
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SBB, 111 PASSB.
use_acc  input  1  1: operand A is the accumulator; 0: operand A is input a.
acc_wr  input  1  1: write the result into the accumulator on acceptance.
a  input  W  operand 1.
b  input  W  operand 2.
out_valid  output  1  q/flags hold a result.
out_ready  input  1  consumer takes the result.
q  output  W  result.
c  output  1  carry (add ops) / borrow (sub ops) of the presented result.
z  output  1  q == 0.
n  output  1  q[W-1].
v  output  1  signed overflow of the presented result.
acc  output  W  current accumulator value.

Behaviour:
- Reset is synchronous, rst high at a clock edge:
  - out_valid=0, q=0, c=0, z=0, n=0, v=0
  - acc=ACC_RST
  - internal carry flag cf=0
  - in_ready reads 1 in the cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: an accepted op at edge k presents q/flags with out_valid=1 after edge k. Throughput is 1 op/cycle when out_ready is held high.
- Holding the result:
  - With out_valid=1 and out_ready=0: q, c, z, n, v stay stable and in_ready=0.
  - Inputs during stall are ignored.
- out_valid is cleared at an edge with transfer and no accept. It stays 1 on simultaneous transfer and accept, and the new result replaces the old.
- Operand A: A = use_acc ? acc : a (acc sampled at the accept edge, before any update).
- Arithmetic, computed at W+1 bits (c = bit W for ADD/ADC):
  - ADD: A+B.
  - ADC: A+B+cf.
  - SUB: A-B, c=1 iff A<B unsigned (borrow).
  - SBB: A-B-cf, c=1 iff A < B+cf unsigned.
- v:
  - Add ops: operand sign bits equal and result sign differs.
  - Sub ops: operand sign bits differ and result sign differs from A.
- Logic ops and PASSB: q=A&B, A|B, A^B, B respectively; c=0, v=0.
- z and n are computed from the final q for every op.
- cf updates to c on every accepted op, including logic ops (cleared). Transactions are chained in accept order.
- Accumulator:
  - On accept with acc_wr=1, acc <= q result (the same edge as the q register update).
  - acc_wr=0 leaves acc unchanged.
  - Back-to-back use_acc ops see the previous op's result with no bubble.
- Reset mid-operation: a pending result is discarded (out_valid=0) and cf/acc restored, regardless of in_valid/out_ready in that cycle.

Optional Feature:
Macro ALU_ACC_PIPE_SAT_EN.
- Defined:
  - ADD/ADC results that carry out clamp q to all-ones.
  - SUB/SBB results that borrow clamp q to 0.
  - c still reports the raw carry/borrow and cf follows c.
  - v is computed from the unsaturated result.
  - z/n are computed from the clamped q.
  - acc receives the clamped value.
- Undefined: results wrap modulo 2^W as specified above.

Test Plan:
1. W=8, reset, then ADD a=0xF0 b=0x20, out_ready=1 -> next cycle q=0x10, c=1, z=0, v=0; in_ready=1 throughout.
2. SUB a=0x05 b=0x07 -> q=0xFE, c=1 (borrow), n=1. Then SBB a=0x10 b=0x00 -> q=0x0F, c=0.
3. Back-pressure: issue 3 ADDs with out_ready=0 after the first -> q holds the first result, in_ready=0, no ops lost. Release out_ready -> results appear in order, one per cycle.
4. Accumulate:
   - PASSB b=0x03 acc_wr=1, then ADD use_acc=1 acc_wr=1 b=0x04 back-to-back -> acc=0x07, q=0x07 on the second result.
   - ADD 0x7F+0x01 -> q=0x80, v=1, n=1.
5. Assert rst while out_valid=1 and acc=0x55 -> next cycle out_valid=0, acc=ACC_RST, flags 0. A following ADC a=1 b=1 gives q=0x02 (cf cleared).
6. With ALU_ACC_PIPE_SAT_EN: ADD 0xF0+0x20 -> q=0xFF, c=1; SUB 0x05-0x07 -> q=0x00, z=1, c=1. Without the macro, case 1 values apply.
